// File: rtl/memory_bus_pkg.sv
// Shared bus types and default widths for the memory arbiter slice.
// Structs use the default widths; parameterised instances size their own slots.
package memory_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 24;
    localparam int ID_W   = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
        logic              write;
        logic [ID_W-1:0]   id;
    } ms_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
    } sm_resp_t;

    // Width of an index that can address n ports, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memory_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
// ptr is assumed to be below N; the caller keeps it in range.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    function automatic int wrap(input int v);
        return (v >= N) ? v - N : v;
    endfunction

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[wrap(int'(ptr) + i)]) begin
                any                        = 1'b1;
                grant[wrap(int'(ptr) + i)] = 1'b1;
                idx                        = IDX_W'(wrap(int'(ptr) + i));
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// N-master round-robin request arbiter with ID-routed responses, one registered slot per path.
// Optional per-master grant counters when MEMORY_ARBITER_STATS_EN is defined.
module memory_arbiter #(
    parameter int N_MASTERS = 4,
    parameter int ADDR_W    = memory_bus_pkg::ADDR_W,
    parameter int DATA_W    = memory_bus_pkg::DATA_W,
    parameter int ID_W      = memory_bus_pkg::ID_W
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_MASTERS-1:0]          m_ms_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_ms_address,
    input  logic [N_MASTERS*DATA_W-1:0]   m_ms_data,
    input  logic [N_MASTERS-1:0]          m_ms_write,
    output logic [N_MASTERS-1:0]          m_ms_take,
    output logic                          s_ms_valid,
    output logic [ADDR_W-1:0]             s_ms_address,
    output logic [DATA_W-1:0]             s_ms_data,
    output logic                          s_ms_write,
    output logic [ID_W-1:0]               s_ms_id,
    input  logic                          s_ms_take,
    input  logic                          s_sm_valid,
    input  logic [DATA_W-1:0]             s_sm_data,
    input  logic [ID_W-1:0]               s_sm_id,
    output logic                          s_sm_take,
    output logic [N_MASTERS-1:0]          m_sm_valid,
    output logic [DATA_W-1:0]             m_sm_data,
    input  logic [N_MASTERS-1:0]          m_sm_take,
    output logic                          bad_id
`ifdef MEMORY_ARBITER_STATS_EN
    ,
    output logic [N_MASTERS*16-1:0]       grant_count
`endif
);

    import memory_bus_pkg::*;

    localparam int IDX_W = idx_width(N_MASTERS);

    logic [IDX_W-1:0]     rr_ptr;
    logic [N_MASTERS-1:0] gnt;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 gnt_any;
    logic                 req_free;
    logic [ADDR_W-1:0]    sel_address;
    logic [DATA_W-1:0]    sel_data;
    logic                 sel_write;
    logic [ID_W-1:0]      gnt_id;

    logic                 resp_valid;
    logic [IDX_W-1:0]     resp_idx;
    logic [DATA_W-1:0]    resp_data;
    logic                 resp_sel_take;
    logic                 resp_id_ok;

    assign req_free = !s_ms_valid || s_ms_take;

    // Holding off the picker during reset keeps any handshake from completing in that cycle.
    rr_arbiter #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req   (m_ms_valid & {N_MASTERS{req_free && !reset}}),
        .ptr   (rr_ptr),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign m_ms_take = gnt;

    always_comb begin
        sel_address = m_ms_address[0 +: ADDR_W];
        sel_data    = m_ms_data[0 +: DATA_W];
        sel_write   = m_ms_write[0];
        for (int k = 0; k < N_MASTERS; k++) begin
            if (gnt[k]) begin
                sel_address = m_ms_address[k*ADDR_W +: ADDR_W];
                sel_data    = m_ms_data[k*DATA_W +: DATA_W];
                sel_write   = m_ms_write[k];
            end
        end
        gnt_id              = '0;
        gnt_id[IDX_W-1:0]   = gnt_idx;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s_ms_valid <= 1'b0;
            rr_ptr     <= '0;
        end else if (gnt_any) begin
            s_ms_valid   <= 1'b1;
            s_ms_address <= sel_address;
            s_ms_data    <= sel_data;
            s_ms_write   <= sel_write;
            s_ms_id      <= gnt_id;
            rr_ptr       <= (gnt_idx == IDX_W'(N_MASTERS - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (s_ms_take) begin
            s_ms_valid <= 1'b0;
        end
    end

    always_comb begin
        resp_sel_take = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (resp_idx == IDX_W'(k)) begin
                resp_sel_take = m_sm_take[k];
            end
        end
    end

    assign s_sm_take  = !reset && (!resp_valid || resp_sel_take);
    assign resp_id_ok = 32'(s_sm_id) < 32'(N_MASTERS);
    assign m_sm_data  = resp_data;

    always_comb begin
        m_sm_valid = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            m_sm_valid[k] = resp_valid && (resp_idx == IDX_W'(k));
        end
    end

    // Out-of-range IDs are swallowed so a bad slave response cannot wedge the path.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid <= 1'b0;
            bad_id     <= 1'b0;
        end else if (s_sm_valid && s_sm_take) begin
            if (resp_id_ok) begin
                resp_valid <= 1'b1;
                resp_idx   <= s_sm_id[IDX_W-1:0];
                resp_data  <= s_sm_data;
            end else begin
                resp_valid <= 1'b0;
                bad_id     <= 1'b1;
            end
        end else if (resp_valid && resp_sel_take) begin
            resp_valid <= 1'b0;
        end
    end

`ifdef MEMORY_ARBITER_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_count <= '0;
        end else begin
            for (int k = 0; k < N_MASTERS; k++) begin
                if (gnt[k] && grant_count[k*16 +: 16] != 16'hFFFF) begin
                    grant_count[k*16 +: 16] <= grant_count[k*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomised scoreboard bench for memory_arbiter: a reference model predicts handshakes
// and pushes expected transfers; a negedge monitor compares what the DUT presents.
module tb_memory_arbiter;

    import memory_bus_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 24;
    localparam int IW = 8;

    logic              clock;
    logic              reset;
    logic [N-1:0]      m_ms_valid;
    logic [N*AW-1:0]   m_ms_address;
    logic [N*DW-1:0]   m_ms_data;
    logic [N-1:0]      m_ms_write;
    logic [N-1:0]      m_ms_take;
    logic              s_ms_valid;
    logic [AW-1:0]     s_ms_address;
    logic [DW-1:0]     s_ms_data;
    logic              s_ms_write;
    logic [IW-1:0]     s_ms_id;
    logic              s_ms_take;
    logic              s_sm_valid;
    logic [DW-1:0]     s_sm_data;
    logic [IW-1:0]     s_sm_id;
    logic              s_sm_take;
    logic [N-1:0]      m_sm_valid;
    logic [DW-1:0]     m_sm_data;
    logic [N-1:0]      m_sm_take;
    logic              bad_id;
`ifdef MEMORY_ARBITER_STATS_EN
    logic [N*16-1:0]   grant_count;
`endif

    memory_arbiter #(
        .N_MASTERS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .ID_W      (IW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .m_ms_valid   (m_ms_valid),
        .m_ms_address (m_ms_address),
        .m_ms_data    (m_ms_data),
        .m_ms_write   (m_ms_write),
        .m_ms_take    (m_ms_take),
        .s_ms_valid   (s_ms_valid),
        .s_ms_address (s_ms_address),
        .s_ms_data    (s_ms_data),
        .s_ms_write   (s_ms_write),
        .s_ms_id      (s_ms_id),
        .s_ms_take    (s_ms_take),
        .s_sm_valid   (s_sm_valid),
        .s_sm_data    (s_sm_data),
        .s_sm_id      (s_sm_id),
        .s_sm_take    (s_sm_take),
        .m_sm_valid   (m_sm_valid),
        .m_sm_data    (m_sm_data),
        .m_sm_take    (m_sm_take),
        .bad_id       (bad_id)
`ifdef MEMORY_ARBITER_STATS_EN
        ,
        .grant_count  (grant_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus state: what each source currently offers.
    logic [N-1:0]  mv;
    logic [AW-1:0] ma [N];
    logic [DW-1:0] md [N];
    logic [N-1:0]  mw;
    logic          s_take;
    logic          sv;
    logic [DW-1:0] sd;
    logic [IW-1:0] sid;
    logic [N-1:0]  mtake;

    // Reference model state.
    int       rr;
    bit       slot_v;
    bit       rslot_v;
    int       rslot_id;
    bit       bad_m;
    int       gcnt [N];
    ms_req_t  req_q [$];
    sm_resp_t resp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply();
        reset = reset;
        for (int k = 0; k < N; k++) begin
            m_ms_valid[k]             = mv[k];
            m_ms_address[k*AW +: AW]  = ma[k];
            m_ms_data[k*DW +: DW]     = md[k];
            m_ms_write[k]             = mw[k];
        end
        s_ms_take  = s_take;
        s_sm_valid = sv;
        s_sm_data  = sd;
        s_sm_id    = sid;
        m_sm_take  = mtake;
    endtask

    task automatic new_req(input int k);
        mv[k] = 1'b1;
        ma[k] = $urandom;
        md[k] = DW'($urandom);
        mw[k] = 1'($urandom);
    endtask

    task automatic new_resp(input int id);
        sv  = 1'b1;
        sid = IW'(id);
        sd  = DW'($urandom);
    endtask

    task automatic model_reset();
        slot_v  = 0;
        rslot_v = 0;
        rr      = 0;
        bad_m   = 0;
        for (int k = 0; k < N; k++) gcnt[k] = 0;
        req_q.delete();
        resp_q.delete();
    endtask

    task automatic model_step();
        int       g;
        bit       free;
        bit       exp_st;
        ms_req_t  rq;
        sm_resp_t rs;
        logic [N-1:0] exp_take;
        logic [N-1:0] exp_msv;

        free = !slot_v || s_take;
        g = -1;
        if (free) begin
            for (int i = 0; i < N; i++) begin
                if (g < 0 && mv[(rr + i) % N]) g = (rr + i) % N;
            end
        end
        exp_take = (g >= 0) ? N'(1 << g) : '0;
        chk("m_ms_take", 64'(m_ms_take), 64'(exp_take));
        chk("s_ms_valid", 64'(s_ms_valid), 64'(slot_v));
        chk("bad_id", 64'(bad_id), 64'(bad_m));

        exp_st  = !rslot_v || mtake[rslot_id];
        exp_msv = rslot_v ? N'(1 << rslot_id) : '0;
        chk("s_sm_take", 64'(s_sm_take), 64'(exp_st));
        chk("m_sm_valid", 64'(m_sm_valid), 64'(exp_msv));

        if (g >= 0) begin
            rq.address = ma[g];
            rq.data    = md[g];
            rq.write   = mw[g];
            rq.id      = IW'(g);
            req_q.push_back(rq);
            rr     = (g + 1) % N;
            mv[g]  = 1'b0;
            slot_v = 1;
            if (gcnt[g] < 16'hFFFF) gcnt[g]++;
        end else if (s_take) begin
            slot_v = 0;
        end

        if (sv && exp_st) begin
            if (int'(sid) < N) begin
                rslot_v  = 1;
                rslot_id = int'(sid);
                rs.data  = sd;
                rs.id    = sid;
                resp_q.push_back(rs);
            end else begin
                bad_m   = 1;
                rslot_v = 0;
            end
            sv = 1'b0;
        end else if (rslot_v && mtake[rslot_id]) begin
            rslot_v = 0;
        end
    endtask

    task automatic cycle();
        apply();
        @(negedge clock);
        #1;
        if (reset) model_reset();
        else model_step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: compares whatever the DUT presents against the head of each expectation queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (s_ms_valid) begin
                if (req_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL req_unexpected: got s_ms_valid=1 expected no pending request");
                end else begin
                    chk("s_ms_address", 64'(s_ms_address), 64'(req_q[0].address));
                    chk("s_ms_data", 64'(s_ms_data), 64'(req_q[0].data));
                    chk("s_ms_write", 64'(s_ms_write), 64'(req_q[0].write));
                    chk("s_ms_id", 64'(s_ms_id), 64'(req_q[0].id));
                    if (s_ms_take) void'(req_q.pop_front());
                end
            end
            if (m_sm_valid != '0) begin
                if (resp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL resp_unexpected: got m_sm_valid=%0h expected 0", m_sm_valid);
                end else begin
                    chk("m_sm_data", 64'(m_sm_data), 64'(resp_q[0].data));
                    chk("m_sm_route", 64'(m_sm_valid), 64'(1) << resp_q[0].id);
                    if ((m_sm_valid & m_sm_take) != '0) void'(resp_q.pop_front());
                end
            end
        end
    end

    initial begin
        mv = '0; mw = '0; mtake = '0;
        for (int k = 0; k < N; k++) begin ma[k] = '0; md[k] = '0; end
        s_take = 1'b0; sv = 1'b0; sd = '0; sid = '0;
        model_reset();
        reset = 1'b1;

        // Reset, then idle inputs.
        repeat (2) cycle();
        reset = 1'b0;
        repeat (2) cycle();

        // All masters requesting continuously: grants rotate 0,1,2,3,0.
        s_take = 1'b1;
        for (int k = 0; k < N; k++) new_req(k);
        repeat (6) begin
            cycle();
            for (int k = 0; k < N; k++) if (!mv[k]) new_req(k);
        end
        repeat (6) cycle();

        // Master 2 payload held by a stalled slave while others wait.
        ma[2] = 32'h1000; md[2] = 24'hABCDEF; mw[2] = 1'b1; mv[2] = 1'b1;
        s_take = 1'b0;
        cycle();
        new_req(0); new_req(1); new_req(3);
        repeat (3) cycle();
        s_take = 1'b1;
        repeat (6) cycle();

        // Response to master 1 held until it takes; next response accepted the same cycle.
        mtake = '0;
        sv = 1'b1; sid = 8'd1; sd = 24'h123456;
        cycle();
        new_resp(0);
        repeat (2) cycle();
        mtake[1] = 1'b1;
        cycle();
        mtake = '1;
        repeat (2) cycle();

        // Out-of-range response ID.
        sv = 1'b1; sid = 8'd7; sd = 24'h0F0F0F;
        repeat (3) cycle();

        // Reset with both slots occupied.
        s_take = 1'b0; mtake = '0;
        new_req(1); new_resp(2);
        cycle();
        new_req(0); new_req(3);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        s_take = 1'b1; mtake = '1;
        repeat (6) cycle();

        // Randomised traffic.
        repeat (3000) begin
            for (int k = 0; k < N; k++) if (!mv[k] && $urandom_range(2) == 0) new_req(k);
            s_take = ($urandom_range(3) != 0);
            if (!sv && $urandom_range(1) == 0)
                new_resp(($urandom_range(15) == 0) ? 4 + $urandom_range(3) : $urandom_range(3));
            mtake = N'($urandom);
            cycle();
        end

        // Drain and confirm nothing was lost.
        s_take = 1'b1; mtake = '1;
        repeat (20) cycle();
        chk("req_q_drained", 64'(req_q.size()), 64'(0));
        chk("resp_q_drained", 64'(resp_q.size()), 64'(0));

`ifdef MEMORY_ARBITER_STATS_EN
        for (int k = 0; k < N; k++) chk("grant_count", 64'(grant_count[k*16 +: 16]), 64'(gcnt[k]));
        repeat (70000) begin
            if (!mv[0]) new_req(0);
            cycle();
        end
        chk("grant_count_sat", 64'(grant_count[15:0]), 64'(16'hFFFF));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Interconnect stage directly upstream of the memory slave endpoint.
- Arbitrates N master request channels (ms) onto one slave request port using round-robin.
- Routes slave responses (sm) back to the originating master by ID.
- Request and response paths are each a one-entry registered slice; the paths are independent.

Parameters:
N_MASTERS, 4, number of master ports (2..16)
ADDR_W, 32, request address width
DATA_W, 24, request/response data width
ID_W, 8, ID width; must satisfy 2**ID_W >= N_MASTERS

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high
m_ms_valid  in  N_MASTERS  per-master request valid
m_ms_address  in  N_MASTERS*ADDR_W  flattened request addresses; master k at [k*ADDR_W +: ADDR_W]
m_ms_data  in  N_MASTERS*DATA_W  flattened write data
m_ms_write  in  N_MASTERS  1 = write, 0 = read
m_ms_take  out  N_MASTERS  one-hot; request accepted this cycle
s_ms_valid  out  1  request to slave valid
s_ms_address  out  ADDR_W  forwarded address
s_ms_data  out  DATA_W  forwarded data
s_ms_write  out  1  forwarded write flag
s_ms_id  out  ID_W  index of originating master
s_ms_take  in  1  slave accepts request
s_sm_valid  in  1  slave response valid
s_sm_data  in  DATA_W  response data
s_sm_id  in  ID_W  response destination master
s_sm_take  out  1  arbiter accepts response
m_sm_valid  out  N_MASTERS  per-master response valid (at most one set)
m_sm_data  out  DATA_W  response data, shared by all masters
m_sm_take  in  N_MASTERS  master accepts response
bad_id  out  1  sticky: a response carried an ID >= N_MASTERS

Behaviour:
- Transfer rule on every channel: valid && take in the same cycle. A valid holds its payload stable until taken.
- Reset values:
  - s_ms_valid=0; slot contents don't-care.
  - resp_valid=0, so m_sm_valid=0.
  - rr_ptr=0, bad_id=0; stat counters=0 when the optional feature is enabled.
  - Reset mid-operation discards buffered request and response; no transfer completes in the reset cycle.
- Request path:
  - req_free = !s_ms_valid || s_ms_take.
  - If req_free, the grant goes to the first k with m_ms_valid[k], scanning rr_ptr, rr_ptr+1, ... modulo N_MASTERS.
  - m_ms_take[g]=1 in that cycle only; m_ms_take is combinational from m_ms_valid, s_ms_valid, s_ms_take and rr_ptr.
  - On grant, the slot loads address/data/write with s_ms_id = g zero-extended; s_ms_valid=1 from the next cycle.
  - rr_ptr <= g+1, wrapping N_MASTERS-1 -> 0.
  - No grant: rr_ptr unchanged; the slot clears if drained.
  - Latency is 1 cycle; throughput is 1 request/cycle when the slave takes continuously.
- Response path:
  - s_sm_take = !resp_valid || (m_sm_take[resp_id] && resp_valid), combinational.
  - On accept, the slot loads data and id.
  - m_sm_valid[k] = resp_valid && resp_id==k.
  - Response with s_sm_id >= N_MASTERS: accepted, not stored (resp_valid not set by it), bad_id <= 1. bad_id clears only on reset.
- Both paths may transfer in the same cycle; neither path stalls the other.

Optional Feature:
MEMORY_ARBITER_STATS_EN
- Defined:
  - Adds output grant_count, width N_MASTERS*16; master k's counter at [k*16 +: 16].
  - Each counter increments on every grant to its master and saturates at 16'hFFFF.
  - Counters reset to 0.
- Undefined: grant_count port and counters are absent; all other behaviour is identical.

Decomposition:
- Package memory_bus_pkg holds:
  - default width constants ADDR_W/DATA_W/ID_W;
  - packed struct ms_req_t {address, data, write, id};
  - packed struct sm_resp_t {data, id}.
- One sub-module, rr_arbiter: N-bit request vector plus pointer in; one-hot grant and index out; purely combinational.
- The top module holds the slots, rr_ptr and counters.

Test Plan:
- Reset, then m_ms_valid=4'b0000 -> s_ms_valid=0, m_ms_take=0, bad_id=0.
- m_ms_valid=4'b1111 held, s_ms_take=1 -> grants 0,1,2,3,0 on consecutive cycles; s_ms_id follows one cycle later.
- Master 2 sends address 32'h1000, write=1, data 24'hABCDEF; s_ms_take=0 for 3 cycles -> payload held stable with s_ms_id=2. While held, m_ms_take stays 0 for all masters.
- Response s_sm_id=1, data 24'h123456 with m_sm_take[1]=0 for 2 cycles -> m_sm_valid=4'b0010 held and s_sm_take=0. Next response is accepted in the same cycle m_sm_take[1]=1.
- Response s_sm_id=7 (N=4) -> s_sm_take=1, m_sm_valid stays 0, bad_id=1 until reset.
- Reset asserted while s_ms_valid=1 and resp_valid=1 -> both 0 the next cycle, rr_ptr=0. With STATS_EN: 70000 grants to master 0 -> grant_count[15:0]=16'hFFFF.
